// File: rtl/instruction_memory.sv
`default_nettype none
// ============================================================================
//  Module   : instruction_memory
//  Purpose  : Registered-read instruction RAM for the fetch path, with a
//             byte-serial program-load port (valid/ready handshake) so that
//             programs can be downloaded at run time.
//  Ports    :
//    Clock, Reset              - single rising-edge clock, async active-high
//    iAddress / iFetchEnable   - fetch request (blocked while a load is busy)
//    oInstruction / oInstructionValid - registered word, valid one cycle later
//    iLoadStart/iLoadBase/iLoadCount  - start a load of iLoadCount words
//    iLoadByte/iLoadByteValid/oLoadByteReady - little-endian byte stream
//    oLoadBusy / oLoadDone / oLoadError      - load status
//  Revision : 1.0 - initial release
// ============================================================================
module instruction_memory #(
    parameter int                    DATA_WIDTH   = 28,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    DEPTH        = 256,
    parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = {DATA_WIDTH{1'b0}}
) (
    input  logic                  Clock,
    input  logic                  Reset,
    // fetch port
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic                  iFetchEnable,
    output logic [DATA_WIDTH-1:0] oInstruction,
    output logic                  oInstructionValid,
    // load port
    input  logic                  iLoadStart,
    input  logic [ADDR_WIDTH-1:0] iLoadBase,
    input  logic [ADDR_WIDTH-1:0] iLoadCount,
    input  logic [7:0]            iLoadByte,
    input  logic                  iLoadByteValid,
    output logic                  oLoadByteReady,
    output logic                  oLoadBusy,
    output logic                  oLoadDone,
    output logic                  oLoadError
);

    localparam int BYTES  = (DATA_WIDTH + 7) / 8;
    localparam int IDX_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // One extra bit so that DEPTH == 2**ADDR_WIDTH is representable.
    localparam logic [ADDR_WIDTH:0] C_DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    C_LAST_IDX = IDX_W'(BYTES - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_WRITE   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;

    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] r_remaining;
    logic [IDX_W-1:0]      r_byte_idx;
    logic [DATA_WIDTH-1:0] r_word;
    logic                  r_error;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_instr;
    logic                  r_instr_valid;

    logic                  w_ready;
    logic                  w_busy;
    logic                  w_done;
    logic                  w_byte_acc;
    logic                  w_ptr_ok;
    logic                  w_addr_ok;
    logic                  w_fetch_acc;
    logic                  w_mem_we;

    assign w_byte_acc  = iLoadByteValid & w_ready;
    assign w_ptr_ok    = ({1'b0, r_ptr} < C_DEPTH_X);
    assign w_addr_ok   = ({1'b0, iAddress} < C_DEPTH_X);
    assign w_fetch_acc = iFetchEnable & ~w_busy;
    // Out-of-range targets are dropped here rather than aliased onto the
    // low index bits.
    assign w_mem_we    = (r_state == S_WRITE) & w_ptr_ok;

    // ------------------------------------------------------------------
    // Load FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Load FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (iLoadStart) begin
                    w_next_state = (iLoadCount != '0) ? S_COLLECT : S_DONE;
                end
            end
            S_COLLECT: begin
                if (w_byte_acc && (r_byte_idx == C_LAST_IDX)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_next_state = (r_remaining == ADDR_WIDTH'(1)) ? S_DONE : S_COLLECT;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_ready = 1'b0;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_ready = 1'b1;
                w_busy  = 1'b1;
            end
            S_WRITE: begin
                w_busy  = 1'b1;
            end
            S_DONE: begin
                w_done  = 1'b1;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load datapath: pointer, word counter, byte assembly, error flag
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ptr       <= '0;
            r_remaining <= '0;
            r_byte_idx  <= '0;
            r_word      <= '0;
            r_error     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iLoadStart) begin
                        r_ptr       <= iLoadBase;
                        r_remaining <= iLoadCount;
                        r_byte_idx  <= '0;
                        r_error     <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (w_byte_acc) begin
                        // Little-endian placement; byte bits that would land
                        // above DATA_WIDTH simply have no destination.
                        for (int b = 0; b < DATA_WIDTH; b++) begin
                            if (r_byte_idx == IDX_W'(b / 8)) begin
                                r_word[b] <= iLoadByte[b % 8];
                            end
                        end
                        r_byte_idx <= r_byte_idx + IDX_W'(1);
                    end
                end
                S_WRITE: begin
                    if (!w_ptr_ok) begin
                        r_error <= 1'b1;
                    end
                    r_ptr       <= r_ptr + ADDR_WIDTH'(1);
                    r_remaining <= r_remaining - ADDR_WIDTH'(1);
                    r_byte_idx  <= '0;
                end
                default: begin
                    r_byte_idx  <= r_byte_idx;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Storage array (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (w_mem_we) begin
            r_mem[r_ptr[MEM_AW-1:0]] <= r_word;
        end
    end

    // ------------------------------------------------------------------
    // Fetch port: registered read, stalled while a load is busy so that a
    // read can never collide with the write of the same cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_instr       <= DEFAULT_WORD;
            r_instr_valid <= 1'b0;
        end else begin
            r_instr_valid <= w_fetch_acc;
            if (w_fetch_acc) begin
                r_instr <= w_addr_ok ? r_mem[iAddress[MEM_AW-1:0]] : DEFAULT_WORD;
            end
        end
    end

    assign oInstruction      = r_instr;
    assign oInstructionValid = r_instr_valid;
    assign oLoadByteReady    = w_ready;
    assign oLoadBusy         = w_busy;
    assign oLoadDone         = w_done;
    assign oLoadError        = r_error;

endmodule
`default_nettype wire

// File: doc/instruction_memory.md
# instruction_memory

Parametrised synchronous instruction memory for the mini-processor fetch path. Replaces a fixed combinational program table with a registered-read RAM of configurable width and depth, plus a byte-serial program-load port with valid/ready handshake, so programs can be downloaded at run time without resynthesis. Sits between the program counter (fetch port) and a host/UART byte source (load port).

## Interface

- DATA_WIDTH, 28, instruction word width (1..64)
- ADDR_WIDTH, 16, address width of fetch and load ports
- DEPTH, 256, number of implemented words (≤ 2^ADDR_WIDTH)
- DEFAULT_WORD, {DATA_WIDTH{1'b0}}, value returned for unimplemented addresses and after reset
- BYTES (local), ceil(DATA_WIDTH/8), bytes per word (4 at default)

- Clock  in  1  single clock, rising edge
- Reset  in  1  asynchronous, active-high
- iAddress  in  ADDR_WIDTH  fetch address
- iFetchEnable  in  1  request a fetch this cycle
- oInstruction  out  DATA_WIDTH  registered fetched word
- oInstructionValid  out  1  high one cycle after each accepted fetch
- iLoadStart  in  1  start a load (sampled only in IDLE)
- iLoadBase  in  ADDR_WIDTH  first word address of load
- iLoadCount  in  ADDR_WIDTH  number of words to load
- iLoadByte  in  8  load data byte
- iLoadByteValid  in  1  byte present
- oLoadByteReady  out  1  block accepts byte this cycle
- oLoadBusy  out  1  load in progress (COLLECT or WRITE)
- oLoadDone  out  1  one-cycle pulse at end of load
- oLoadError  out  1  sticky: a word targeted address ≥ DEPTH; cleared by next accepted iLoadStart

## Operation

- Reset values: oInstruction=DEFAULT_WORD, oInstructionValid=0, oLoadByteReady=0, oLoadBusy=0, oLoadDone=0, oLoadError=0, FSM=IDLE. Memory array is not cleared.
- Fetch: accepted when iFetchEnable=1 and oLoadBusy=0. Next edge: oInstruction <= mem[iAddress] if iAddress < DEPTH else DEFAULT_WORD; oInstructionValid <= 1. Otherwise oInstruction holds, oInstructionValid <= 0.
- Load FSM states IDLE, COLLECT, WRITE, DONE:
  - IDLE: ready=0. iLoadStart=1, iLoadCount≠0 → COLLECT; ptr=iLoadBase, remaining=iLoadCount, byte_idx=0, error cleared. iLoadCount=0 → DONE (no writes, error cleared).
  - COLLECT: ready=1, busy=1. Byte accepted when valid&ready; stored little-endian (byte k → bits 8k+7:8k); bits above DATA_WIDTH discarded. Accepting byte BYTES-1 → WRITE.
  - WRITE: ready=0, busy=1, one cycle. ptr < DEPTH: mem[ptr] written at the closing edge; else write skipped, oLoadError set. ptr increments modulo 2^ADDR_WIDTH; remaining decrements; remaining reaches 0 → DONE, else COLLECT (byte_idx=0).
  - DONE: oLoadDone=1, busy=0, one cycle → IDLE.
- iLoadStart outside IDLE is ignored. Bytes offered outside COLLECT are not consumed.
- Fetch in the DONE cycle returns newly written data (no read-during-write hazard; fetch blocked while busy).
- Reset mid-load: FSM → IDLE immediately, partial word discarded; words already written remain.

## Timing

- Fetch latency: 1 cycle, address sampled at edge, data valid after it.
- Start sampled at edge t0; with iLoadByteValid held high each word takes BYTES+1 cycles; oLoadDone high during cycle after edge t0+(BYTES+1)·N (t0+5N at default).
- Zero-count load: oLoadDone high in cycle after t0.
- Gaps in iLoadByteValid stretch COLLECT only; no timeout.

## Test plan

- Reset asserted mid-cycle → all outputs at reset values immediately (oInstruction=0, ready/busy/done/error=0).
- Start base=4 count=2, bytes 78,56,34,12,EF,CD,AB,9A back-to-back → oLoadDone at t0+10; fetch 4 → 28'h2345678, fetch 5 → 28'hAABCDEF, each one cycle after request with oInstructionValid=1.
- Fetch iAddress=300 (DEPTH=256) → DEFAULT_WORD; iFetchEnable=0 next cycle → output held, oInstructionValid=0.
- Load with randomised valid bubbles and iFetchEnable=1 throughout → fetches stalled (valid=0, output held) while busy; final contents identical to back-to-back case.
- Start base=255 count=2 → mem[255] written, second word dropped, oLoadError=1 and sticky, oLoadDone still pulses at t0+10; next start clears error.
- Reset after 2 bytes of a word → IDLE, busy=0, target word unchanged; then start count=0 → oLoadDone pulse next cycle, no memory change.
